reg_file_rename: RTL and testbench
==================================

Name: reg_file_rename

Overview:
- Architectural register file plus per-register rename tag, directly downstream of the reorder buffer's commit port.
- Decode reads operands through it (value, or the ROB tag still producing the value) and renames rd on issue.
- ROB commit writes architectural values and clears a tag only when the tag still matches.
- Misbranch flush clears all rename tags.

Parameters:
- REG_NUM, 32, number of architectural registers (x0 hardwired to zero)
- DATA_W, 32, register value width
- ROB_TAG_W, 4, ROB tag width; tag 0 means "no pending producer"

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- rdy  in  1  global enable; no state change when low
- in_decode_rs1  in  5  source register 1 index
- in_decode_rs2  in  5  source register 2 index
- out_decode_value1  out  DATA_W  rs1 value (meaningful when out_decode_reorder1 == 0)
- out_decode_reorder1  out  ROB_TAG_W  rs1 pending ROB tag, 0 = value ready
- out_decode_value2  out  DATA_W  rs2 value
- out_decode_reorder2  out  ROB_TAG_W  rs2 pending ROB tag
- in_decode_rd  in  5  destination register being issued
- in_decode_rd_reorder  in  ROB_TAG_W  ROB tag assigned to rd; 0 = no rename this cycle
- in_rob_index  in  5  committing register index; 0 = no commit
- in_rob_value  in  DATA_W  committing value
- in_rob_reorder  in  ROB_TAG_W  ROB tag of the committing entry
- in_misbranch  in  1  flush: clear all rename tags

Behaviour:
- State: value[REG_NUM] and tag[REG_NUM]. On rst (async), all values and tags are 0. No registered outputs; reads are combinational.
- Read, per port, index r:
  - r == 0: value 0, tag 0.
  - Otherwise, if a commit is active with in_rob_index == r and in_rob_reorder == tag[r] (bypass): value = in_rob_value, tag = 0.
  - Otherwise: value[r], tag[r].
  - Reads ignore the same-cycle rename; a rename is visible from the next cycle.
- Update at posedge clk, only when rdy == 1, applied in this order:
  1. Commit (in_rob_index != 0): value[idx] <= in_rob_value unconditionally. tag[idx] <= 0 only if tag[idx] == in_rob_reorder; otherwise the tag is kept, because a younger producer is pending.
  2. Rename (in_decode_rd != 0 and in_decode_rd_reorder != 0 and in_misbranch == 0): tag[rd] <= in_decode_rd_reorder. This overrides a same-cycle tag clear on the same register.
  3. Flush (in_misbranch == 1): all tags <= 0. Overrides rename. The commit value write in the same cycle is still performed, because the ROB asserts commit and misbranch together for JALR.
- x0: writes and renames to index 0 are discarded; tag[0] is always 0.
- rdy == 0: all state holds; combinational reads remain valid.
- A stale commit (tag mismatch) still updates the value, so the architectural state stays correct after a later flush.
- Reset asserted mid-cycle clears state immediately, regardless of clk.

Optional Feature:
- Macro REGFILE_COMMIT_BYPASS_EN.
- Defined: same-cycle commit bypass on both read ports, as described above.
- Undefined: reads reflect stored state only. Decode relies on the ROB's update broadcast to resolve a tag committed in that same cycle. This saves two comparators and muxes.

Decomposition:
- Shared defines header: DATA_WIDTH, REG_TAG_WIDTH, ROB_TAG_WIDTH, ZERO_REG_TAG, ZERO_ROB_TAG, TRUE/FALSE.
- One natural sub-module: reg_file_read_port. It does the combinational lookup, the x0 handling and the bypass, and is instantiated twice.

Test Plan:
- Reset then read rs1=5, rs2=0 -> value1=0, reorder1=0, value2=0, reorder2=0.
- Rename x5 with tag 3, next cycle read rs1=5 -> reorder1=3. Commit (idx 5, value 0xDEADBEEF, tag 3), next cycle -> value1=0xDEADBEEF, reorder1=0.
- Rename x7 with tag 2, then rename x7 with tag 4, then commit (7, 0x11, tag 2) -> value[7]=0x11, reorder stays 4. Commit (7, 0x22, tag 4) -> reorder 0, value 0x22.
- Same cycle: commit (9, 0x55, tag 1) with tag[9]=1, and rename x9 with tag 6 -> after the edge value[9]=0x55, tag[9]=6. With the bypass enabled, during that cycle read rs2=9 -> value 0x55, reorder 0.
- Tags pending on x1/x2/x3, then in_misbranch=1 with commit (1, 0x99, tag 5) and rename x4 with tag 7 -> all tags 0, value[1]=0x99, x4 not renamed.
- Other cases:
  - rdy=0 with commit and rename asserted -> no change.
  - Write to x0 with 0xFFFFFFFF -> x0 reads 0.
  - Assert rst between clock edges -> tags clear immediately.

Source files
------------

// File: rtl/reg_file_rename_pkg.sv
// reg_file_rename shared definitions.
// Widths, zero tags and boolean constants used by the register file.
package reg_file_rename_pkg;

    localparam int REG_NUM       = 32;
    localparam int DATA_WIDTH    = 32;
    localparam int REG_TAG_WIDTH = 5;
    localparam int ROB_TAG_WIDTH = 4;

    localparam logic [REG_TAG_WIDTH-1:0] ZERO_REG_TAG = '0;
    localparam logic [ROB_TAG_WIDTH-1:0] ZERO_ROB_TAG = '0;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/reg_file_rename_if.sv
// reg_file_rename decode/commit bundle.
// master = decode + ROB side, slave = register file.
interface reg_file_rename_if
    import reg_file_rename_pkg::*;
#(
    parameter int DATA_W    = DATA_WIDTH,
    parameter int ROB_TAG_W = ROB_TAG_WIDTH
);
    logic [REG_TAG_WIDTH-1:0] in_decode_rs1;
    logic [REG_TAG_WIDTH-1:0] in_decode_rs2;
    logic [DATA_W-1:0]        out_decode_value1;
    logic [ROB_TAG_W-1:0]     out_decode_reorder1;
    logic [DATA_W-1:0]        out_decode_value2;
    logic [ROB_TAG_W-1:0]     out_decode_reorder2;
    logic [REG_TAG_WIDTH-1:0] in_decode_rd;
    logic [ROB_TAG_W-1:0]     in_decode_rd_reorder;
    logic [REG_TAG_WIDTH-1:0] in_rob_index;
    logic [DATA_W-1:0]        in_rob_value;
    logic [ROB_TAG_W-1:0]     in_rob_reorder;
    logic                     in_misbranch;

    modport master (
        output in_decode_rs1, in_decode_rs2,
        output in_decode_rd, in_decode_rd_reorder,
        output in_rob_index, in_rob_value, in_rob_reorder,
        output in_misbranch,
        input  out_decode_value1, out_decode_reorder1,
        input  out_decode_value2, out_decode_reorder2
    );

    modport slave (
        input  in_decode_rs1, in_decode_rs2,
        input  in_decode_rd, in_decode_rd_reorder,
        input  in_rob_index, in_rob_value, in_rob_reorder,
        input  in_misbranch,
        output out_decode_value1, out_decode_reorder1,
        output out_decode_value2, out_decode_reorder2
    );

endinterface

// File: rtl/reg_file_read_port.sv
// One combinational operand lookup: x0 forced to zero, optional
// same-cycle commit bypass when REGFILE_COMMIT_BYPASS_EN is defined.
module reg_file_read_port
    import reg_file_rename_pkg::*;
#(
    parameter int REG_NUM   = 32,
    parameter int DATA_W    = DATA_WIDTH,
    parameter int ROB_TAG_W = ROB_TAG_WIDTH
) (
    input  logic [REG_TAG_WIDTH-1:0]          idx,
    input  logic [REG_NUM-1:0][DATA_W-1:0]    values,
    input  logic [REG_NUM-1:0][ROB_TAG_W-1:0] tags,
    input  logic                              commit_en,
    input  logic [REG_TAG_WIDTH-1:0]          commit_idx,
    input  logic [DATA_W-1:0]                 commit_value,
    input  logic [ROB_TAG_W-1:0]              commit_tag,
    output logic [DATA_W-1:0]                 value,
    output logic [ROB_TAG_W-1:0]              tag
);

`ifndef REGFILE_COMMIT_BYPASS_EN
    logic unused_commit;
    assign unused_commit = ^{commit_en, commit_idx,
                             commit_value, commit_tag};
`endif

    // Select stored (or bypassed) value and tag; x0 always reads ready zero.
    always_comb begin
        value = '0;
        tag   = '0;
        if (idx != ZERO_REG_TAG) begin
`ifdef REGFILE_COMMIT_BYPASS_EN
            if (commit_en && commit_idx == idx
                && commit_tag == tags[idx]) begin
                value = commit_value;
                tag   = '0;
            end else begin
                value = values[idx];
                tag   = tags[idx];
            end
`else
            value = values[idx];
            tag   = tags[idx];
`endif
        end
    end

endmodule

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register ROB rename tags.
// Optional macro: REGFILE_COMMIT_BYPASS_EN (same-cycle commit bypass).
module reg_file_rename
    import reg_file_rename_pkg::*;
#(
    parameter int REG_NUM   = 32,
    parameter int DATA_W    = DATA_WIDTH,
    parameter int ROB_TAG_W = ROB_TAG_WIDTH
) (
    input logic               clk,
    input logic               rst,
    input logic               rdy,
    reg_file_rename_if.slave  bus
);

    logic [REG_NUM-1:0][DATA_W-1:0]    values;
    logic [REG_NUM-1:0][ROB_TAG_W-1:0] tags;
    logic                              commit_en;
    logic                              rename_en;

    assign commit_en = (bus.in_rob_index != ZERO_REG_TAG);
    assign rename_en = (bus.in_decode_rd != ZERO_REG_TAG)
                    && (bus.in_decode_rd_reorder != '0)
                    && !bus.in_misbranch;

    // Commit writes the value always; the tag clears only if it is still
    // the committing producer. Rename then overrides, flush overrides all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            values <= '0;
            tags   <= '0;
        end else if (rdy) begin
            if (commit_en) begin
                values[bus.in_rob_index] <= bus.in_rob_value;
                if (tags[bus.in_rob_index] == bus.in_rob_reorder) begin
                    tags[bus.in_rob_index] <= '0;
                end
            end
            if (bus.in_misbranch) begin
                tags <= '0;
            end else if (rename_en) begin
                tags[bus.in_decode_rd] <= bus.in_decode_rd_reorder;
            end
        end
    end

    reg_file_read_port #(
        .REG_NUM   (REG_NUM),
        .DATA_W    (DATA_W),
        .ROB_TAG_W (ROB_TAG_W)
    ) u_rd1 (
        .idx          (bus.in_decode_rs1),
        .values       (values),
        .tags         (tags),
        .commit_en    (commit_en),
        .commit_idx   (bus.in_rob_index),
        .commit_value (bus.in_rob_value),
        .commit_tag   (bus.in_rob_reorder),
        .value        (bus.out_decode_value1),
        .tag          (bus.out_decode_reorder1)
    );

    reg_file_read_port #(
        .REG_NUM   (REG_NUM),
        .DATA_W    (DATA_W),
        .ROB_TAG_W (ROB_TAG_W)
    ) u_rd2 (
        .idx          (bus.in_decode_rs2),
        .values       (values),
        .tags         (tags),
        .commit_en    (commit_en),
        .commit_idx   (bus.in_rob_index),
        .commit_value (bus.in_rob_value),
        .commit_tag   (bus.in_rob_reorder),
        .value        (bus.out_decode_value2),
        .tag          (bus.out_decode_reorder2)
    );

endmodule

// File: tb/tb_reg_file_rename.sv
// Testbench for reg_file_rename: directed scenarios plus random traffic
// checked against an array-based reference model.
module tb_reg_file_rename;

    logic clk;
    logic rst;
    logic rdy;
    int   errors;
    int   checks;

    logic [31:0] mval [32];
    logic [3:0]  mtag [32];

    reg_file_rename_if bus ();

    reg_file_rename dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.in_decode_rs1        = '0;
        bus.in_decode_rs2        = '0;
        bus.in_decode_rd         = '0;
        bus.in_decode_rd_reorder = '0;
        bus.in_rob_index         = '0;
        bus.in_rob_value         = '0;
        bus.in_rob_reorder       = '0;
        bus.in_misbranch         = 1'b0;
        rdy                      = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mval[i] = '0;
            mtag[i] = '0;
        end
    endtask

    // Architectural effect of one rising edge on the model.
    task automatic model_edge();
        int ci;
        int ri;
        ci = int'(bus.in_rob_index);
        ri = int'(bus.in_decode_rd);
        if (rdy) begin
            if (ci != 0) begin
                mval[ci] = bus.in_rob_value;
                if (mtag[ci] == bus.in_rob_reorder) mtag[ci] = 4'd0;
            end
            if (bus.in_misbranch) begin
                for (int i = 0; i < 32; i++) mtag[i] = 4'd0;
            end else if (ri != 0 && bus.in_decode_rd_reorder != 0) begin
                mtag[ri] = bus.in_decode_rd_reorder;
            end
        end
    endtask

    // Expected read for register r given current inputs and model state.
    task automatic model_read(input int r,
                              output logic [31:0] v,
                              output logic [3:0] t);
        v = '0;
        t = '0;
        if (r != 0) begin
            v = mval[r];
            t = mtag[r];
`ifdef REGFILE_COMMIT_BYPASS_EN
            if (int'(bus.in_rob_index) == r
                && bus.in_rob_reorder == mtag[r]) begin
                v = bus.in_rob_value;
                t = '0;
            end
`endif
        end
    endtask

    // Advance one edge: inputs are held from the previous negedge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.in_decode_rs1 = 5'd5;
        bus.in_decode_rs2 = 5'd0;
        #1;
        checks += 4;
        if (bus.out_decode_value1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_v1 got=%h exp=0", bus.out_decode_value1);
        end
        if (bus.out_decode_reorder1 !== 4'd0) begin
            errors++;
            $display("FAIL reset_t1 got=%h exp=0", bus.out_decode_reorder1);
        end
        if (bus.out_decode_value2 !== 32'd0) begin
            errors++;
            $display("FAIL reset_v2 got=%h exp=0", bus.out_decode_value2);
        end
        if (bus.out_decode_reorder2 !== 4'd0) begin
            errors++;
            $display("FAIL reset_t2 got=%h exp=0", bus.out_decode_reorder2);
        end
    endtask

    task automatic test_rename_commit();
        clear_inputs();
        bus.in_decode_rd = 5'd5;
        bus.in_decode_rd_reorder = 4'd3;
        step();
        clear_inputs();
        bus.in_decode_rs1 = 5'd5;
        #1;
        checks++;
        if (bus.out_decode_reorder1 !== 4'd3) begin
            errors++;
            $display("FAIL rename_t got=%h exp=3", bus.out_decode_reorder1);
        end
        bus.in_rob_index = 5'd5;
        bus.in_rob_value = 32'hDEADBEEF;
        bus.in_rob_reorder = 4'd3;
        step();
        clear_inputs();
        bus.in_decode_rs1 = 5'd5;
        #1;
        checks += 2;
        if (bus.out_decode_value1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL commit_v got=%h exp=deadbeef",
                     bus.out_decode_value1);
        end
        if (bus.out_decode_reorder1 !== 4'd0) begin
            errors++;
            $display("FAIL commit_t got=%h exp=0", bus.out_decode_reorder1);
        end
    endtask

    task automatic test_stale_commit();
        clear_inputs();
        bus.in_decode_rd = 5'd7;
        bus.in_decode_rd_reorder = 4'd2;
        step();
        bus.in_decode_rd_reorder = 4'd4;
        step();
        clear_inputs();
        bus.in_rob_index = 5'd7;
        bus.in_rob_value = 32'h11;
        bus.in_rob_reorder = 4'd2;
        step();
        clear_inputs();
        bus.in_decode_rs2 = 5'd7;
        #1;
        checks += 2;
        if (bus.out_decode_value2 !== 32'h11) begin
            errors++;
            $display("FAIL stale_v got=%h exp=11", bus.out_decode_value2);
        end
        if (bus.out_decode_reorder2 !== 4'd4) begin
            errors++;
            $display("FAIL stale_t got=%h exp=4", bus.out_decode_reorder2);
        end
        bus.in_rob_index = 5'd7;
        bus.in_rob_value = 32'h22;
        bus.in_rob_reorder = 4'd4;
        step();
        clear_inputs();
        bus.in_decode_rs2 = 5'd7;
        #1;
        checks += 2;
        if (bus.out_decode_value2 !== 32'h22) begin
            errors++;
            $display("FAIL young_v got=%h exp=22", bus.out_decode_value2);
        end
        if (bus.out_decode_reorder2 !== 4'd0) begin
            errors++;
            $display("FAIL young_t got=%h exp=0", bus.out_decode_reorder2);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] ev;
        logic [3:0]  et;
        clear_inputs();
        bus.in_decode_rd = 5'd9;
        bus.in_decode_rd_reorder = 4'd1;
        step();
        clear_inputs();
        bus.in_rob_index = 5'd9;
        bus.in_rob_value = 32'h55;
        bus.in_rob_reorder = 4'd1;
        bus.in_decode_rd = 5'd9;
        bus.in_decode_rd_reorder = 4'd6;
        bus.in_decode_rs2 = 5'd9;
`ifdef REGFILE_COMMIT_BYPASS_EN
        ev = 32'h55;
        et = 4'd0;
`else
        ev = 32'h0;
        et = 4'd1;
`endif
        #1;
        checks += 2;
        if (bus.out_decode_value2 !== ev) begin
            errors++;
            $display("FAIL bypass_v got=%h exp=%h", bus.out_decode_value2, ev);
        end
        if (bus.out_decode_reorder2 !== et) begin
            errors++;
            $display("FAIL bypass_t got=%h exp=%h",
                     bus.out_decode_reorder2, et);
        end
        step();
        clear_inputs();
        bus.in_decode_rs2 = 5'd9;
        #1;
        checks += 2;
        if (bus.out_decode_value2 !== 32'h55) begin
            errors++;
            $display("FAIL same_v got=%h exp=55", bus.out_decode_value2);
        end
        if (bus.out_decode_reorder2 !== 4'd6) begin
            errors++;
            $display("FAIL same_t got=%h exp=6", bus.out_decode_reorder2);
        end
    endtask

    task automatic test_flush();
        clear_inputs();
        for (int i = 1; i <= 3; i++) begin
            bus.in_decode_rd = 5'(i);
            bus.in_decode_rd_reorder = 4'(i + 8);
            step();
        end
        clear_inputs();
        bus.in_misbranch = 1'b1;
        bus.in_rob_index = 5'd1;
        bus.in_rob_value = 32'h99;
        bus.in_rob_reorder = 4'd5;
        bus.in_decode_rd = 5'd4;
        bus.in_decode_rd_reorder = 4'd7;
        step();
        clear_inputs();
        bus.in_decode_rs1 = 5'd1;
        bus.in_decode_rs2 = 5'd2;
        #1;
        checks += 3;
        if (bus.out_decode_value1 !== 32'h99) begin
            errors++;
            $display("FAIL flush_v1 got=%h exp=99", bus.out_decode_value1);
        end
        if (bus.out_decode_reorder1 !== 4'd0) begin
            errors++;
            $display("FAIL flush_t1 got=%h exp=0", bus.out_decode_reorder1);
        end
        if (bus.out_decode_reorder2 !== 4'd0) begin
            errors++;
            $display("FAIL flush_t2 got=%h exp=0", bus.out_decode_reorder2);
        end
        bus.in_decode_rs1 = 5'd3;
        bus.in_decode_rs2 = 5'd4;
        #1;
        checks += 2;
        if (bus.out_decode_reorder1 !== 4'd0) begin
            errors++;
            $display("FAIL flush_t3 got=%h exp=0", bus.out_decode_reorder1);
        end
        if (bus.out_decode_reorder2 !== 4'd0) begin
            errors++;
            $display("FAIL flush_t4 got=%h exp=0", bus.out_decode_reorder2);
        end
    endtask

    task automatic test_rdy();
        clear_inputs();
        bus.in_decode_rd = 5'd10;
        bus.in_decode_rd_reorder = 4'd5;
        step();
        clear_inputs();
        rdy = 1'b0;
        bus.in_rob_index = 5'd10;
        bus.in_rob_value = 32'hAB;
        bus.in_rob_reorder = 4'd5;
        bus.in_decode_rd = 5'd11;
        bus.in_decode_rd_reorder = 4'd2;
        bus.in_misbranch = 1'b0;
        step();
        clear_inputs();
        bus.in_decode_rs1 = 5'd10;
        bus.in_decode_rs2 = 5'd11;
        #1;
        checks += 3;
        if (bus.out_decode_value1 !== 32'h0) begin
            errors++;
            $display("FAIL rdy_v got=%h exp=0", bus.out_decode_value1);
        end
        if (bus.out_decode_reorder1 !== 4'd5) begin
            errors++;
            $display("FAIL rdy_t got=%h exp=5", bus.out_decode_reorder1);
        end
        if (bus.out_decode_reorder2 !== 4'd0) begin
            errors++;
            $display("FAIL rdy_rn got=%h exp=0", bus.out_decode_reorder2);
        end
    endtask

    task automatic test_x0();
        clear_inputs();
        bus.in_rob_index = 5'd0;
        bus.in_rob_value = 32'hFFFFFFFF;
        bus.in_rob_reorder = 4'd0;
        bus.in_decode_rd = 5'd0;
        bus.in_decode_rd_reorder = 4'd3;
        step();
        clear_inputs();
        bus.in_decode_rs1 = 5'd0;
        #1;
        checks += 2;
        if (bus.out_decode_value1 !== 32'h0) begin
            errors++;
            $display("FAIL x0_v got=%h exp=0", bus.out_decode_value1);
        end
        if (bus.out_decode_reorder1 !== 4'd0) begin
            errors++;
            $display("FAIL x0_t got=%h exp=0", bus.out_decode_reorder1);
        end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        bus.in_decode_rd = 5'd12;
        bus.in_decode_rd_reorder = 4'd9;
        step();
        clear_inputs();
        bus.in_decode_rs1 = 5'd12;
        bus.in_decode_rs2 = 5'd1;
        #1;
        checks++;
        if (bus.out_decode_reorder1 !== 4'd9) begin
            errors++;
            $display("FAIL pre_rst_t got=%h exp=9", bus.out_decode_reorder1);
        end
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        checks += 2;
        if (bus.out_decode_reorder1 !== 4'd0) begin
            errors++;
            $display("FAIL arst_t got=%h exp=0", bus.out_decode_reorder1);
        end
        if (bus.out_decode_value2 !== 32'd0) begin
            errors++;
            $display("FAIL arst_v got=%h exp=0", bus.out_decode_value2);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] ev1, ev2;
        logic [3:0]  et1, et2;
        int          ci;
        for (int n = 0; n < 400; n++) begin
            bus.in_decode_rs1 = 5'($urandom_range(0, 31));
            bus.in_decode_rs2 = 5'($urandom_range(0, 31));
            bus.in_decode_rd = 5'($urandom_range(0, 31));
            bus.in_decode_rd_reorder = 4'($urandom_range(0, 15));
            ci = $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) ci = 0;
            bus.in_rob_index = 5'(ci);
            bus.in_rob_value = $urandom;
            if ($urandom_range(0, 1) == 0) bus.in_rob_reorder = mtag[ci];
            else bus.in_rob_reorder = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0 && ci != 0)
                bus.in_decode_rs1 = 5'(ci);
            bus.in_misbranch = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 7) != 0);
            #1;
            model_read(int'(bus.in_decode_rs1), ev1, et1);
            model_read(int'(bus.in_decode_rs2), ev2, et2);
            checks += 2;
            if (bus.out_decode_value1 !== ev1
                || bus.out_decode_reorder1 !== et1) begin
                errors++;
                $display("FAIL rnd_p1 n=%0d r=%0d got=%h/%h exp=%h/%h",
                         n, bus.in_decode_rs1, bus.out_decode_value1,
                         bus.out_decode_reorder1, ev1, et1);
            end
            if (bus.out_decode_value2 !== ev2
                || bus.out_decode_reorder2 !== et2) begin
                errors++;
                $display("FAIL rnd_p2 n=%0d r=%0d got=%h/%h exp=%h/%h",
                         n, bus.in_decode_rs2, bus.out_decode_value2,
                         bus.out_decode_reorder2, ev2, et2);
            end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_rename_commit();
        test_stale_commit();
        test_same_cycle();
        test_flush();
        test_rdy();
        test_x0();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
